// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU definitions for the instruction fetch unit: fetch states,
// reset vector, PC increment and the word-alignment helper.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd4;

    // Redirect targets are always word aligned; the low two bits are ignored.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word fetches to instruction memory, presents
// fetched instructions to IF/ID, and handles hazard holds and branch redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o,
    output logic        valid_o,
    output logic        cpu_stall_o
);

    fetch_state_t state_q, state_d;
    logic [31:0]  req_q, req_d;
    logic [31:0]  redir_q, redir_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;
    logic [31:0]  target;

    assign target = align_word(branch_pc_i);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        redir_d = redir_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;

        unique case (state_q)
            IDLE: begin
                // Any ack seen here belongs to a request abandoned by reset.
                state_d = WAIT;
                if (branch_i) begin
                    req_d   = target;
                    valid_d = 1'b0;
                end
            end

            WAIT: begin
                if (branch_i) begin
                    valid_d = 1'b0;
                    if (imem_ack_i) begin
                        req_d = target;
                    end else begin
                        // Memory still owes us the old word; park the target.
                        redir_d = target;
                        state_d = DROP;
                    end
                end else if (imem_ack_i) begin
                    pc_d    = req_q;
                    instr_d = imem_data_i;
                    valid_d = 1'b1;
                    req_d   = req_q + PC_STEP;
                    state_d = stall_i ? HOLD : WAIT;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                end
            end

            HOLD: begin
                if (branch_i) begin
                    req_d   = target;
                    valid_d = 1'b0;
                    state_d = WAIT;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = WAIT;
                end
            end

            DROP: begin
                valid_d = 1'b0;
                if (imem_ack_i) begin
                    // Stale word is discarded; a branch arriving with it wins.
                    req_d   = branch_i ? target : redir_q;
                    state_d = WAIT;
                end else if (branch_i) begin
                    redir_d = target;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            req_q   <= RESET_PC;
            redir_q <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            redir_q <= redir_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign imem_req_o  = (state_q == WAIT) || (state_q == DROP);
    assign imem_addr_o = req_q;
    assign cpu_stall_o = ((state_q == WAIT) && !imem_ack_i) || (state_q == DROP);
    assign pc_o        = pc_q;
    assign instr_o     = instr_q;
    assign valid_o     = valid_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed fetch/hold/redirect/reset
// scenarios followed by randomized traffic against a transaction-level model.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i;
    logic [31:0] imem_data_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        valid_o;
    logic        cpu_stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    instr_fetch_unit dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .stall_i     (stall_i),
        .branch_i    (branch_i),
        .branch_pc_i (branch_pc_i),
        .imem_req_o  (imem_req_o),
        .imem_addr_o (imem_addr_o),
        .imem_ack_i  (imem_ack_i),
        .imem_data_i (imem_data_i),
        .pc_o        (pc_o),
        .instr_o     (instr_o),
        .valid_o     (valid_o),
        .cpu_stall_o (cpu_stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: what the fetch unit has promised, in transaction terms.
    bit          m_started;    // first clock after reset has happened
    bit          m_in_flight;  // a memory request is outstanding
    bit          m_discard;    // outstanding request's data is to be thrown away
    bit          m_held;       // presented instruction frozen by a hazard
    logic [31:0] m_addr;       // address of the outstanding / next request
    logic [31:0] m_redir;      // where to go once a discarded word returns
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_started   = 0;
        m_in_flight = 0;
        m_discard   = 0;
        m_held      = 0;
        m_addr      = 32'h0;
        m_redir     = 32'h0;
        m_pc        = 32'h0;
        m_instr     = 32'h0;
        m_valid     = 0;
    endtask

    task automatic model_clock(input bit s, input bit b, input logic [31:0] t, input bit a,
                               input logic [31:0] d);
        logic [31:0] tgt;
        tgt = {t[31:2], 2'b00};
        if (b) m_valid = 0;
        if (!m_started) begin
            m_started   = 1;
            m_in_flight = 1;
            if (b) m_addr = tgt;
        end else if (m_held) begin
            if (b) m_addr = tgt;
            if (b || !s) begin
                m_held      = 0;
                m_in_flight = 1;
                m_valid     = 0;
            end
        end else if (m_discard) begin
            if (a) begin
                m_addr    = b ? tgt : m_redir;
                m_discard = 0;
            end else if (b) begin
                m_redir = tgt;
            end
        end else if (b) begin
            if (a) m_addr = tgt;
            else begin
                m_redir   = tgt;
                m_discard = 1;
            end
        end else if (a) begin
            m_pc    = m_addr;
            m_instr = d;
            m_valid = 1;
            m_addr  = m_addr + 32'd4;
            if (s) begin
                m_held      = 1;
                m_in_flight = 0;
            end
        end else if (!s) begin
            m_valid = 0;
        end
    endtask

    // One clock: drive inputs just after a falling edge, check, then advance.
    task automatic step(input bit s, input bit b, input logic [31:0] t, input bit a);
        logic [31:0] d;
        d           = mem_word(m_addr);
        stall_i     = s;
        branch_i    = b;
        branch_pc_i = t;
        imem_ack_i  = a;
        imem_data_i = d;
        #1;
        check("imem_req", {31'b0, imem_req_o}, {31'b0, m_in_flight});
        check("imem_addr", imem_addr_o, m_addr);
        check("cpu_stall", {31'b0, cpu_stall_o},
              {31'b0, (m_in_flight && !m_discard && !a) || m_discard});
        check("pc", pc_o, m_pc);
        check("instr", instr_o, m_instr);
        check("valid", {31'b0, valid_o}, {31'b0, m_valid});
        model_clock(s, b, t, a, d);
        @(posedge clk_i);
        @(negedge clk_i);
        $display("[TB] t=%0t stall=%0b br=%0b ack=%0b -> addr=%h pc=%h valid=%0b",
                 $time, s, b, a, imem_addr_o, pc_o, valid_o);
    endtask

    // Asserts reset between clock edges and checks outputs clear without a clock.
    task automatic do_reset();
        #2;
        rst_i      = 1'b0;
        stall_i    = 1'b0;
        branch_i   = 1'b0;
        imem_ack_i = 1'b0;
        #1;
        check("rst_req", {31'b0, imem_req_o}, 32'h0);
        check("rst_addr", imem_addr_o, 32'h0);
        check("rst_stall", {31'b0, cpu_stall_o}, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        model_reset();
        @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        rst_i       = 1'b0;
        stall_i     = 1'b0;
        branch_i    = 1'b0;
        branch_pc_i = 32'h0;
        imem_ack_i  = 1'b0;
        imem_data_i = 32'h0;
        model_reset();
        #1;
        check("init_valid", {31'b0, valid_o}, 32'h0);
        check("init_req", {31'b0, imem_req_o}, 32'h0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Back-to-back fetch, then a 3-cycle late ack on 0x8.
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("addr_at_8", imem_addr_o, 32'h8);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("late_ack_valid", {31'b0, valid_o}, 32'h0);
        step(0, 0, 0, 1);
        check("pc_8", pc_o, 32'h8);
        step(0, 0, 0, 1);

        // Hazard hold on the fetch of 0x10.
        step(1, 0, 0, 1);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        check("hold_pc", pc_o, 32'h10);
        check("hold_req", {31'b0, imem_req_o}, 32'h0);
        step(0, 0, 0, 0);
        check("after_hold_addr", imem_addr_o, 32'h14);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);

        // Redirect to 0x103 while 0x20 is outstanding.
        check("pre_drop_addr", imem_addr_o, 32'h20);
        step(0, 1, 32'h103, 0);
        step(0, 0, 0, 1);
        check("drop_valid", {31'b0, valid_o}, 32'h0);
        check("redir_addr", imem_addr_o, 32'h100);
        step(0, 0, 0, 1);

        // Branch and stall together while holding.
        step(1, 0, 0, 1);
        step(1, 1, 32'h40, 0);
        check("hold_br_addr", imem_addr_o, 32'h40);
        check("hold_br_valid", {31'b0, valid_o}, 32'h0);

        // PC wrap, then reset mid-wait at the top of memory.
        step(0, 1, 32'hFFFF_FFFE, 1);
        step(0, 0, 0, 1);
        check("wrap_addr", imem_addr_o, 32'h0);
        step(0, 1, 32'hFFFF_FFFC, 1);
        step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 0, 1);
        check("late_ack_ignored", {31'b0, valid_o}, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit s, b, a;
            logic [31:0] t;
            s = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 7) == 0);
            t = $urandom();
            a = m_in_flight && ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(s, b, t, a);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
